// File: rtl/led_step_pkg.sv
// led_step_pkg: shared debounce state encoding, speed levels and step period table
package led_step_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_FILT, PRESSED, REL_FILT} deb_state_t;
  localparam logic [1:0] SPD_1000MS = 2'd0;
  localparam logic [1:0] SPD_500MS  = 2'd1;
  localparam logic [1:0] SPD_250MS  = 2'd2;
  localparam logic [1:0] SPD_125MS  = 2'd3;
  localparam logic [15:0] PERIOD_TBL = {4'd1, 4'd2, 4'd4, 4'd8};
  function automatic logic [3:0] step_period(input logic [1:0] spd);
    return PERIOD_TBL[{spd, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer plus debounce FSM giving a press pulse and a held level
module key_debounce
  import led_step_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_held
);
  logic [1:0] sync;
  logic [19:0] cnt;
  deb_state_t state;
  logic key_s;
  assign key_s = sync[1];
  assign key_held = (state == PRESSED) || (state == REL_FILT);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      key_flag <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      key_flag <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!key_s) state <= PRESS_FILT;
        end
        PRESS_FILT:
          if (key_s) begin
            state <= IDLE;
            cnt <= '0;
          end else if (cnt == DEBOUNCE_MAX) begin
            state <= PRESSED;
            cnt <= '0;
            key_flag <= 1'b1;
          end else cnt <= cnt + 20'd1;
        PRESSED: begin
          cnt <= '0;
          if (key_s) state <= REL_FILT;
        end
        REL_FILT:
          if (!key_s) begin
            state <= PRESSED;
            cnt <= '0;
          end else if (cnt == DEBOUNCE_MAX) begin
            state <= IDLE;
            cnt <= '0;
          end else cnt <= cnt + 20'd1;
      endcase
    end
endmodule

// File: rtl/led_step_gen.sv
// led_step_gen: key-controlled step-rate generator for a water-LED shifter
// LED_STEP_PAUSE_EN adds long-press pause toggling with speed change deferred to release
module led_step_gen
  import led_step_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999,
  parameter logic [22:0] PRESCALE_MAX = 23'd6_249_999,
  parameter logic [25:0] LONG_MAX     = 26'd49_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       step_tick,
  output logic [1:0] speed_sel,
  output logic       key_flag,
  output logic       paused
);
  logic key_held, spd_inc, run, base, period_done;
  logic [22:0] pre;
  logic [3:0] stp;
  key_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_key (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_held (key_held)
  );
`ifdef LED_STEP_PAUSE_EN
  logic [25:0] hold_cnt;
  logic long_done, held_d;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      hold_cnt <= '0;
      long_done <= 1'b0;
      held_d <= 1'b0;
      paused <= 1'b0;
    end else begin
      held_d <= key_held;
      if (!key_held) begin
        hold_cnt <= '0;
        long_done <= 1'b0;
      end else if (!long_done) begin
        if (hold_cnt == LONG_MAX) begin
          paused <= ~paused;
          long_done <= 1'b1;
        end else hold_cnt <= hold_cnt + 26'd1;
      end
    end
  // a short hold changes speed on release; a long hold only toggles pause
  assign spd_inc = held_d && !key_held && !long_done;
  assign run = !paused;
`else
  logic unused_pause;
  assign unused_pause = ^{key_held, LONG_MAX};
  assign spd_inc = key_flag;
  assign paused = 1'b0;
  assign run = 1'b1;
`endif
  assign base = pre == PRESCALE_MAX;
  assign period_done = stp == step_period(speed_sel) - 4'd1;
  // a speed change restarts the period and swallows any coincident step
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      pre <= '0;
      stp <= '0;
      speed_sel <= SPD_500MS;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (spd_inc) begin
        speed_sel <= speed_sel + 2'd1;
        pre <= '0;
        stp <= '0;
      end else if (run) begin
        pre <= base ? '0 : pre + 23'd1;
        if (base) begin
          stp <= period_done ? '0 : stp + 4'd1;
          step_tick <= period_done;
        end
      end
    end
endmodule

// File: doc/led_step_gen.md
LED_STEP_GEN -- requirements
Module: led_step_gen

Interface
REQ-001 Parameter DEBOUNCE_MAX, default 20'd999_999: debounce window minus one, in clocks (20 ms @ 50 MHz).
REQ-002 Parameter PRESCALE_MAX, default 23'd6_249_999: base-tick period minus one, in clocks (125 ms @ 50 MHz).
REQ-003 Parameter LONG_MAX, default 26'd49_999_999: long-press hold time minus one, in clocks (1 s @ 50 MHz).
REQ-004 sys_clk  input  1  system clock, all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_in  input  1  raw push-button, asynchronous, active-low (0 = pressed).
REQ-007 step_tick  output  1  one-cycle pulse per LED shift step, consumed by the water-LED shifter.
REQ-008 speed_sel  output  2  current speed level, 0 = slowest.
REQ-009 key_flag  output  1  one-cycle pulse per confirmed press.
REQ-010 paused  output  1  1 = stepping halted.

Function
REQ-011 key_in SHALL pass a 2-FF synchronizer before any use.
REQ-012 Debounce FSM SHALL have states IDLE, PRESS_FILT, PRESSED, REL_FILT.
- IDLE->PRESS_FILT on synced key = 0.
- PRESS_FILT->PRESSED when the filter counter reaches DEBOUNCE_MAX with key still 0.
- PRESS_FILT->IDLE on any key = 1; counter cleared.
- PRESSED->REL_FILT on key = 1.
- REL_FILT->IDLE at DEBOUNCE_MAX with key still 1.
- REL_FILT->PRESSED on any key = 0.
REQ-013 key_flag SHALL pulse for exactly one cycle, in the cycle the FSM enters PRESSED.
REQ-014 A prescale counter SHALL count 0..PRESCALE_MAX and wrap; wrap cycle = base tick.
REQ-015 Step period in base ticks SHALL be 8, 4, 2, 1 for speed_sel 0, 1, 2, 3.
- Step counter increments on each base tick.
- step_tick asserted for one cycle on the base tick that completes the period.
- Step counter then cleared.
REQ-016 On key_flag (short press), speed_sel SHALL increment modulo 4 (3->0).
- Prescale and step counters cleared in the same cycle.
- The first step_tick at the new speed occurs one full new period later.
REQ-017 If key_flag and a would-be step_tick coincide, the speed change SHALL win and step_tick SHALL be suppressed.
REQ-018 Outputs SHALL be registered; no combinational path from key_in to any output.

Reset
REQ-019 On reset:
- FSM = IDLE; all counters = 0; speed_sel = 2'd1 (500 ms steps).
- step_tick = 0, key_flag = 0, paused = 0.
REQ-020 Reset asserted mid-press or mid-period SHALL abort the operation immediately.
- No step_tick or key_flag pulse after reset release until freshly earned.

Configuration
REQ-021 Macro LED_STEP_PAUSE_EN defined:
- A hold in PRESSED reaching LONG_MAX clocks SHALL toggle paused, once per hold.
- That press SHALL NOT change speed_sel.
- key_flag still pulses at PRESSED entry.
- The speed increment is deferred to release and applied only if the hold was short.
- While paused = 1, counters are frozen and step_tick = 0.
- Unpausing resumes from the frozen count.
REQ-022 Macro LED_STEP_PAUSE_EN undefined:
- No long-press logic; paused tied to 0.
- Speed increments on key_flag per REQ-016.

Structure
REQ-023 Package led_step_pkg SHALL hold:
- the debounce state encoding;
- speed level constants SPD_1000MS..SPD_125MS;
- the period table 8/4/2/1.
REQ-024 Synchronizer + debounce FSM SHALL be a sub-module key_debounce.
- Outputs: key_flag and a level key_held.
- Instantiated once.

Verification (DEBOUNCE_MAX=9, PRESCALE_MAX=3, LONG_MAX=99)
REQ-025 Release reset, no key:
- speed_sel = 1.
- step_tick every 16 clocks, first pulse 16 clocks after reset release.
REQ-026 key_in low for 30 clocks:
- one key_flag about 12 clocks after the falling edge.
- speed_sel 1->2; step_tick now every 8 clocks.
REQ-027 Bounce key_in low 5 / high 3 / low 5 clocks, then high:
- no key_flag; speed_sel unchanged.
REQ-028 Four clean presses from speed_sel = 3:
- wraps to 0, then 1, 2, 3; tick periods 32, 16, 8, 4 clocks.
REQ-029 Align key_flag with the step_tick cycle:
- step_tick suppressed; next tick one new period later.
- Separately, assert reset mid-press: no key_flag after release.
REQ-030 With LED_STEP_PAUSE_EN, hold key 150 clocks:
- paused = 1; no step_tick; speed_sel unchanged.
- A second long hold clears paused; ticks resume.
